// File: rtl/irrigation_pkg.sv
// Shared types and default timing constants for the irrigation sequencer.
// State encodings double as the display state code.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN_S    = 3'd1,
    ST_RUN_D    = 3'd2,
    ST_DEAD     = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam int DEF_TICK_DIV       = 50_000_000;
  localparam int DEF_DEBOUNCE_TICKS = 3;
  localparam int DEF_MIN_RUN_TICKS  = 10;
  localparam int DEF_DEAD_TICKS     = 2;
  localparam int DEF_COOLDOWN_TICKS = 5;
  localparam int DEF_CNT_W          = 8;

  typedef struct packed {
    logic sprinkler;
    logic dripper;
  } valves_t;

  // Only the two run states ever open a valve, and never both.
  function automatic valves_t valves_for(state_t s);
    valves_t v;
    v = '0;
    case (s)
      ST_RUN_S: v.sprinkler = 1'b1;
      ST_RUN_D: v.dripper   = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic state_t run_state(logic sprinkler);
    return sprinkler ? ST_RUN_S : ST_RUN_D;
  endfunction

endpackage

// File: rtl/tick_generator.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks;
// the first tick lands TICK_DIV clocks after reset release.
module tick_generator
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/irrigation_sequencer.sv
// Valve sequencer: request debounce, minimum run, changeover dead time,
// cooldown lockout and a latched fault with blinking alarm.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int MIN_RUN_TICKS  = DEF_MIN_RUN_TICKS,
  parameter int DEAD_TICKS     = DEF_DEAD_TICKS,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       irrigation_request,
  input  logic       splinker_mode_request,
  input  logic       conflicting_values,
  input  logic       high_water_level,
  input  logic       mid_water_level,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       water_supply_valvule,
  output logic       alarm,
  output logic [2:0] state_code,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DEBOUNCE_C = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] MIN_RUN_C  = CNT_W'(MIN_RUN_TICKS);
  localparam logic [CNT_W-1:0] DEAD_C     = CNT_W'(DEAD_TICKS);
  localparam logic [CNT_W-1:0] COOLDOWN_C = CNT_W'(COOLDOWN_TICKS);

  logic tick;

  tick_generator #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CNT_W-1:0]  count_inc, count_tick;
  logic              mode_reg, mode_next;
  logic              drop_reg, drop_next;
  logic              blink_reg, blink_next;
  valves_t           valves_next;

  always_comb begin
    count_inc  = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
    // Elapsed ticks including the one (if any) arriving this clock.
    count_tick = tick ? count_inc : count_reg;

    state_next = state_reg;
    count_next = count_reg;
    mode_next  = mode_reg;
    drop_next  = drop_reg;
    blink_next = blink_reg;

    if (conflicting_values) begin
      state_next = ST_FAULT;
      count_next = '0;
      if (state_reg != ST_FAULT) begin
        blink_next = 1'b1;
      end else if (tick) begin
        blink_next = ~blink_reg;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!irrigation_request) begin
            count_next = '0;
          end else begin
            count_next = count_tick;
            if (count_tick >= DEBOUNCE_C) begin
              mode_next  = splinker_mode_request;
              state_next = run_state(splinker_mode_request);
            end
          end
        end

        ST_RUN_S, ST_RUN_D: begin
          count_next = count_tick;
          if (count_tick >= MIN_RUN_C) begin
            if (!irrigation_request) begin
              state_next = ST_COOLDOWN;
            end else if (splinker_mode_request != mode_reg) begin
              state_next = ST_DEAD;
              drop_next  = 1'b0;
            end
          end
        end

        ST_DEAD: begin
          count_next = count_tick;
          drop_next  = drop_reg | ~irrigation_request;
          if (count_tick >= DEAD_C) begin
            if (drop_reg || !irrigation_request) begin
              state_next = ST_COOLDOWN;
            end else begin
              mode_next  = ~mode_reg;
              state_next = run_state(~mode_reg);
            end
          end
        end

        ST_COOLDOWN: begin
          count_next = count_tick;
          if (count_tick >= COOLDOWN_C) begin
            state_next = ST_IDLE;
          end
        end

        ST_FAULT: begin
          count_next = count_tick;
          if (tick) begin
            blink_next = ~blink_reg;
          end
          if (count_tick >= DEBOUNCE_C) begin
            state_next = ST_COOLDOWN;
          end
        end

        default: state_next = ST_IDLE;
      endcase

      if (state_next != state_reg) begin
        count_next = '0;
      end
    end

    valves_next = valves_for(state_next);
  end

  // Outputs are decoded from the next state so they switch with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg            <= ST_IDLE;
      count_reg            <= '0;
      mode_reg             <= 1'b0;
      drop_reg             <= 1'b0;
      blink_reg            <= 1'b0;
      splinker_bomb        <= 1'b0;
      dripper_valvule      <= 1'b0;
      water_supply_valvule <= 1'b0;
      alarm                <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state_reg            <= state_next;
      count_reg            <= count_next;
      mode_reg             <= mode_next;
      drop_reg             <= drop_next;
      blink_reg            <= blink_next;
      splinker_bomb        <= valves_next.sprinkler;
      dripper_valvule      <= valves_next.dripper;
      water_supply_valvule <= (state_next != ST_FAULT) & ~high_water_level;
      alarm                <= (state_next == ST_FAULT) ? blink_next : ~mid_water_level;
      busy                 <= (state_next != ST_IDLE);
    end
  end

  assign state_code = state_reg;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Scenario bench for irrigation_sequencer with a short tick; expected state
// transitions are queued ahead of time and popped when the state code changes.
module tb_irrigation_sequencer;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       irrigation_request = 1'b0;
  logic       splinker_mode_request = 1'b0;
  logic       conflicting_values = 1'b0;
  logic       high_water_level = 1'b1;
  logic       mid_water_level = 1'b1;
  logic       splinker_bomb;
  logic       dripper_valvule;
  logic       water_supply_valvule;
  logic       alarm;
  logic [2:0] state_code;
  logic       busy;

  irrigation_sequencer #(
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (3),
    .MIN_RUN_TICKS  (4),
    .DEAD_TICKS     (2),
    .COOLDOWN_TICKS (3),
    .CNT_W          (8)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .irrigation_request    (irrigation_request),
    .splinker_mode_request (splinker_mode_request),
    .conflicting_values    (conflicting_values),
    .high_water_level      (high_water_level),
    .mid_water_level       (mid_water_level),
    .splinker_bomb         (splinker_bomb),
    .dripper_valvule       (dripper_valvule),
    .water_supply_valvule  (water_supply_valvule),
    .alarm                 (alarm),
    .state_code            (state_code),
    .busy                  (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] code;
    logic       bomb;
    logic       drip;
    logic       water;
    logic       alm;
  } snap_t;

  snap_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         edges = 0;
  int         run_edge = 0;
  logic [2:0] prev_code = 3'd0;

  // Rising edges since reset release; ticks land on multiples of TD.
  always @(posedge clock or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  function automatic snap_t observe();
    snap_t s;
    s.code  = state_code;
    s.bomb  = splinker_bomb;
    s.drip  = dripper_valvule;
    s.water = water_supply_valvule;
    s.alm   = alarm;
    return s;
  endfunction

  function automatic void expect_state(logic [2:0] c, logic b, logic d, logic a);
    snap_t s;
    s.code  = c;
    s.bomb  = b;
    s.drip  = d;
    s.water = 1'b0;
    s.alm   = a;
    exp_q.push_back(s);
  endfunction

  // Advance to the next falling edge and score any state transition.
  task automatic cycle();
    snap_t obs, e;
    @(negedge clock);
    if (reset) begin
      prev_code = 3'd0;
    end else begin
      checks++;
      if (splinker_bomb && dripper_valvule) begin
        errors++;
        $display("FAIL valve_exclusive edge=%0d bomb=%b drip=%b required not both 1",
                 edges, splinker_bomb, dripper_valvule);
      end
      if (state_code !== prev_code) begin
        obs = observe();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition edge=%0d got code=%0d bomb=%b drip=%b water=%b alarm=%b required no change",
                   edges, obs.code, obs.bomb, obs.drip, obs.water, obs.alm);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL transition edge=%0d got code=%0d bomb=%b drip=%b water=%b alarm=%b required code=%0d bomb=%b drip=%b water=%b alarm=%b",
                     edges, obs.code, obs.bomb, obs.drip, obs.water, obs.alm,
                     e.code, e.bomb, e.drip, e.water, e.alm);
          end else begin
            $display("transition edge=%0d code=%0d bomb=%b drip=%b water=%b alarm=%b",
                     edges, obs.code, obs.bomb, obs.drip, obs.water, obs.alm);
          end
        end
        prev_code = state_code;
      end
    end
  endtask

  task automatic wait_tick();
    do cycle(); while (edges % TD != 0);
  endtask

  task automatic wait_code(input logic [2:0] code, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (state_code === code) begin
        at = edges;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_code timeout code=%0d got %0d after %0d cycles", code, state_code, limit);
  endtask

  task automatic check_edge(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s edge got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) cycle();
    checks++;
    if ({state_code, splinker_bomb, dripper_valvule, water_supply_valvule, alarm, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got code=%0d bomb=%b drip=%b water=%b alarm=%b busy=%b required all 0",
               state_code, splinker_bomb, dripper_valvule, water_supply_valvule, alarm, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_run_start();
    int at;
    irrigation_request    = 1'b1;
    splinker_mode_request = 1'b1;
    expect_state(3'd1, 1'b1, 1'b0, 1'b0);
    wait_code(3'd1, 40, at);
    check_edge("run_start", at, 3 * TD);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL run_busy got %b required 1", busy);
    end
    run_edge = at;
  endtask

  task automatic test_mode_change();
    int at, at2;
    wait_tick();
    splinker_mode_request = 1'b0;
    expect_state(3'd3, 1'b0, 1'b0, 1'b0);
    expect_state(3'd2, 1'b0, 1'b1, 1'b0);
    wait_code(3'd3, 40, at);
    check_edge("dead_entry", at, run_edge + 4 * TD);
    wait_code(3'd2, 40, at2);
    check_edge("run_d_entry", at2, at + 2 * TD);
    run_edge = at2;
  endtask

  task automatic test_cooldown();
    int at, at2;
    for (int i = 0; i < 40 && edges < run_edge + 4 * TD + 1; i++) cycle();
    irrigation_request = 1'b0;
    expect_state(3'd4, 1'b0, 1'b0, 1'b0);
    wait_code(3'd4, 10, at);
    check_edge("cooldown_entry", at, run_edge + 4 * TD + 2);
    cycle();
    irrigation_request = 1'b1;
    expect_state(3'd0, 1'b0, 1'b0, 1'b0);
    wait_code(3'd0, 30, at2);
    check_edge("cooldown_exit", at2, at + 2 + 2 * TD);
    irrigation_request    = 1'b0;
    splinker_mode_request = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b required 0", busy);
    end
  endtask

  task automatic test_sensors();
    high_water_level = 1'b0;
    mid_water_level  = 1'b0;
    cycle();
    checks++;
    if ({water_supply_valvule, alarm} !== 2'b11) begin
      errors++;
      $display("FAIL sensors_low got water=%b alarm=%b required 1 1", water_supply_valvule, alarm);
    end
    high_water_level = 1'b1;
    mid_water_level  = 1'b1;
    cycle();
    checks++;
    if ({water_supply_valvule, alarm} !== 2'b00) begin
      errors++;
      $display("FAIL sensors_high got water=%b alarm=%b required 0 0", water_supply_valvule, alarm);
    end
  endtask

  task automatic test_debounce_restart();
    int t0, at;
    wait_tick();
    t0 = edges;
    irrigation_request = 1'b1;
    repeat (2) wait_tick();
    cycle();
    irrigation_request = 1'b0;
    repeat (2) cycle();
    irrigation_request = 1'b1;
    expect_state(3'd1, 1'b1, 1'b0, 1'b0);
    wait_code(3'd1, 40, at);
    check_edge("debounce_restart", at, t0 + 5 * TD);
    run_edge = at;
  endtask

  task automatic test_fault();
    int tf, at;
    for (int i = 0; i < 8 && edges % TD != TD - 1; i++) cycle();
    conflicting_values = 1'b1;
    expect_state(3'd5, 1'b0, 1'b0, 1'b1);
    cycle();
    conflicting_values = 1'b0;
    tf = edges;
    high_water_level = 1'b0;
    cycle();
    checks++;
    if (water_supply_valvule !== 1'b0) begin
      errors++;
      $display("FAIL fault_water got %b required 0", water_supply_valvule);
    end
    high_water_level = 1'b1;
    wait_tick();
    checks++;
    if ({state_code, alarm} !== {3'd5, 1'b0}) begin
      errors++;
      $display("FAIL fault_tick1 got code=%0d alarm=%b required 5 0", state_code, alarm);
    end
    cycle();
    conflicting_values = 1'b1;
    cycle();
    conflicting_values = 1'b0;
    wait_tick();
    checks++;
    if ({state_code, alarm} !== {3'd5, 1'b1}) begin
      errors++;
      $display("FAIL fault_tick2 got code=%0d alarm=%b required 5 1", state_code, alarm);
    end
    wait_tick();
    checks++;
    if ({state_code, alarm} !== {3'd5, 1'b0}) begin
      errors++;
      $display("FAIL fault_tick3 got code=%0d alarm=%b required 5 0", state_code, alarm);
    end
    expect_state(3'd4, 1'b0, 1'b0, 1'b0);
    expect_state(3'd0, 1'b0, 1'b0, 1'b0);
    expect_state(3'd1, 1'b1, 1'b0, 1'b0);
    wait_code(3'd4, 20, at);
    check_edge("fault_exit", at, tf + 4 * TD);
    wait_code(3'd0, 30, at);
    check_edge("fault_cooldown_exit", at, tf + 7 * TD);
    wait_code(3'd1, 30, at);
    check_edge("rerun_after_fault", at, tf + 10 * TD);
    run_edge = at;
  endtask

  task automatic test_async_reset();
    cycle();
    checks++;
    if (splinker_bomb !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bomb got %b required 1", splinker_bomb);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({splinker_bomb, dripper_valvule, state_code, busy} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got bomb=%b drip=%b code=%0d busy=%b required all 0",
               splinker_bomb, dripper_valvule, state_code, busy);
    end
    cycle();
    reset                 = 1'b0;
    irrigation_request    = 1'b0;
    splinker_mode_request = 1'b0;
    repeat (8) cycle();
    checks++;
    if ({state_code, splinker_bomb, dripper_valvule, busy} !== 6'b0) begin
      errors++;
      $display("FAIL after_reset got code=%0d bomb=%b drip=%b busy=%b required all 0",
               state_code, splinker_bomb, dripper_valvule, busy);
    end
  endtask

  initial begin
    test_reset();
    test_run_start();
    test_mode_change();
    test_cooldown();
    test_sensors();
    test_debounce_restart();
    test_fault();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
